ram_line_bridge: RTL
====================

# ram_line_bridge

Cache-side front end for the DRAM core's host port. Converts 32-bit word and cache-line requests from the L1 refill/writeback logic into halfword-granular host transactions (`host_req`/`host_ack`, `host_txd`/`host_txd_ack`, `host_rxd`/`host_rxd_vld`). For writes it buffers the whole payload first, so the host data stream never stalls. For reads it packs halfword pairs into 32-bit words.

## Interface
- `LINE_WORDS`, default 8: words per cache line; must be a power of two, ≥2.
- `clk  in  1`: single clock; every flop is on the rising edge.
- `rst  in  1`: synchronous, active-low reset.
- `c_req  in  1`: request strobe; sampled only in IDLE.
- `c_rwn  in  1`: 1 = read, 0 = write.
- `c_line  in  1`: 1 = full line (LINE_WORDS words), 0 = single word.
- `c_addr  in  32`: byte address.
- `c_wstb  in  4`: byte enables for word writes; ignored for line writes (treated as 4'hF).
- `c_wvld  in  1`, `c_wdat  in  32`: write-data beat.
- `c_wrdy  out  1`: the bridge accepts a write beat.
- `c_rvld  out  1`, `c_rdat  out  32`: read-data beat (one-cycle pulse).
- `c_busy  out  1`: high from request accept through `c_done`.
- `c_done  out  1`: one-cycle completion pulse.
- `host_req, host_rwn, host_burst  out  1`, `host_addr  out  32`: host command.
- `host_ack  in  1`: command accepted.
- `host_txm  out  2`, `host_txd  out  16`: write halfword and its byte write mask (1 = write byte).
- `host_txd_ack  in  1`: halfword consumed.
- `host_rxd  in  16`, `host_rxd_vld  in  1`: read halfword.

## Operation
- States: IDLE, WFILL, REQ, WDATA, RDATA, DONE.
- **IDLE.** On `c_req=1` the bridge latches `rwn`, `line`, address and `wstb`, sets `c_busy`, and clears counters.
  - Read: go to REQ.
  - Write: go to WFILL.
- **Address.** `host_addr` is `c_addr` with the low 2 bits cleared for a word operation, or the low log2(LINE_WORDS·4) bits cleared for a line operation. `host_burst = line`.
- **Beat count.** N = LINE_WORDS for a line, 1 for a word. Halfword count H = 2N.
- **WFILL.** `c_wrdy=1`. Each cycle with `c_wvld & c_wrdy`, store `c_wdat` into buffer[widx] and increment `widx`. After the N-th beat, go to REQ. `c_wrdy` is 0 in the cycle after the last beat.
- **REQ.** `host_req=1` and `host_rwn` are held until the cycle where `host_ack=1`; `host_req` drops in the next cycle. Next state is WDATA for a write, RDATA for a read.
  - `host_txd`/`host_txm` already present halfword 0 while in REQ, because the core may ack data from the cycle it acks the command.
- **WDATA.** Halfword k is `buffer[k>>1][15:0]` for even k and `[31:16]` for odd k (little-endian).
  - `host_txm`: 2'b11 for lines; `wstb[1:0]` (even k) or `wstb[3:2]` (odd k) for words.
  - k increments on each `host_txd_ack` and drives the next halfword combinationally from k.
  - On the ack of halfword H−1, go to DONE.
- **RDATA.**
  - An even-index `host_rxd_vld` latches the low half.
  - An odd-index one registers `c_rdat = {host_rxd, low}` and pulses `c_rvld` in the following cycle.
  - On the H-th halfword, go to DONE.
- **DONE.** `c_done=1` for one cycle, `c_busy` drops in the same cycle, then return to IDLE.
- **Ignored inputs.**
  - `host_txd_ack` outside REQ/WDATA.
  - `host_rxd_vld` outside REQ/RDATA.
  - `host_ack` outside REQ.
  - `c_req` while busy (the caller must hold it or re-issue).
  - `c_wvld` outside WFILL.
- **Overflow.** Counters saturate at H and never wrap. An extra `txd_ack`/`rxd_vld` in the same cycle as the DONE transition is dropped.

## Timing
- Reset (`rst=0` at a rising edge): state IDLE, all counters 0, and every output low: `c_wrdy`, `c_rvld`, `c_busy`, `c_done`, `host_req`, `host_rwn`, `host_burst`, `host_addr`, `host_txm`, `host_txd`, and `c_rdat`=0.
- Reset mid-transaction aborts it: no `c_done`, and `host_req` is low in the next cycle.
- Read: `c_req` at cycle 0 → `host_req` at cycle 1. The final odd `host_rxd_vld` at cycle T → last `c_rvld` at T+1 and `c_done` at T+1. No bubble is required between consecutive `c_rvld` pulses when `rxd_vld` arrives back-to-back.
- Write: `c_req` at 0 → `c_wrdy` at 1. Last write beat at W → `host_req` at W+1. Last `host_txd_ack` at T → `c_done` at T+1.
- `c_busy` is high from cycle 1 through the cycle before `c_done`, and low during the `c_done` cycle.
- Minimum turnaround: a new `c_req` is accepted the cycle after `c_done`.
- All outputs are registered except `host_txd`/`host_txm`, which are a mux from registered buffer and index.

## Test plan
- **Line read.** `c_req`, rwn=1, line=1, addr=0x0000_103C, core acks at cycle 3 and returns 16 halfwords 0x0001..0x0010 back-to-back → `host_addr`=0x0000_1020, `host_burst`=1, 8 `c_rvld` with `c_rdat`=0x0002_0001…0x0010_000F, `c_done` the same cycle as the last `c_rvld`.
- **Word write with strobes.** addr=0x0000_0206, wstb=4'b0110, wdat=0xAABB_CCDD → `host_addr`=0x0000_0204, `host_burst`=0, halfword 0 = 0xCCDD with txm=2'b10, halfword 1 = 0xAABB with txm=2'b01, `c_done` one cycle after the second `txd_ack`.
- **Line write with stalled feed.** `c_wvld` gaps of 2 cycles → `host_req` only after the 8th beat; txd order is word0.lo, word0.hi, …, txm=2'b11 throughout, `txd_ack` stalls of 0–3 cycles tolerated.
- **Delayed ack.** `host_ack` withheld for 20 cycles → `host_req` stays high, `host_txd` holds halfword 0, and no counter advances.
- **Reset mid-read.** `rst`=0 after the 5th `rxd_vld` → next cycle all outputs 0 and no `c_done`. A fresh word read afterwards completes normally with 2 halfwords.
- **Spurious handshakes.** `host_rxd_vld`/`host_txd_ack` pulses in IDLE, and `c_req` while busy → no `c_rvld`, no state change, and the in-flight transaction is unaffected.

Source files
------------

// File: rtl/ram_line_bridge_if.sv
// Cache-side and host-side signal bundle for ram_line_bridge.
// The bridge connects through the slave modport. Its environment uses the master modport.
interface ram_line_bridge_if;
  logic        c_req;
  logic        c_rwn;
  logic        c_line;
  logic [31:0] c_addr;
  logic [3:0]  c_wstb;
  logic        c_wvld;
  logic [31:0] c_wdat;
  logic        c_wrdy;
  logic        c_rvld;
  logic [31:0] c_rdat;
  logic        c_busy;
  logic        c_done;
  logic        host_req;
  logic        host_rwn;
  logic        host_burst;
  logic [31:0] host_addr;
  logic        host_ack;
  logic [1:0]  host_txm;
  logic [15:0] host_txd;
  logic        host_txd_ack;
  logic [15:0] host_rxd;
  logic        host_rxd_vld;

  modport slave (
    input  c_req, c_rwn, c_line, c_addr, c_wstb, c_wvld, c_wdat,
    input  host_ack, host_txd_ack, host_rxd, host_rxd_vld,
    output c_wrdy, c_rvld, c_rdat, c_busy, c_done,
    output host_req, host_rwn, host_burst, host_addr, host_txm, host_txd
  );

  modport master (
    output c_req, c_rwn, c_line, c_addr, c_wstb, c_wvld, c_wdat,
    output host_ack, host_txd_ack, host_rxd, host_rxd_vld,
    input  c_wrdy, c_rvld, c_rdat, c_busy, c_done,
    input  host_req, host_rwn, host_burst, host_addr, host_txm, host_txd
  );
endinterface

// File: rtl/ram_line_bridge.sv
// Bridges 32-bit word and cache-line requests onto the halfword-granular DRAM host port.
// Write payloads are fully buffered before the host command is issued.
module ram_line_bridge #(
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic             clk,
  input  logic             rst,
  ram_line_bridge_if.slave bus
);
  localparam int unsigned LW = $clog2(LINE_WORDS);
  localparam int unsigned CW = LW + 2;
  localparam logic [31:0]   LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
  localparam logic [CW-1:0] H_LINE    = CW'(2 * LINE_WORDS);
  localparam logic [LW:0]   N_LINE    = (LW + 1)'(LINE_WORDS);

  typedef enum logic [2:0] {IDLE, WFILL, REQ, WDATA, RDATA, DONE} state_t;

  state_t        state;
  logic          rwn;
  logic          line;
  logic [3:0]    wstb;
  logic [LW:0]   widx;
  logic [CW-1:0] tcnt;
  logic [CW-1:0] rcnt;
  logic [15:0]   rlo;
  logic [31:0]   buffer [LINE_WORDS];

  logic [CW-1:0] hmax;
  logic [LW:0]   nmax;
  logic          wfire, tfire, rfire, tlast, rlast, xfer_done;
  logic [31:0]   tword;

  assign hmax  = line ? H_LINE : CW'(2);
  assign nmax  = line ? N_LINE : (LW + 1)'(1);
  assign wfire = (state == WFILL) && bus.c_wvld && bus.c_wrdy;
  assign tfire = (state == REQ || state == WDATA) && !rwn && bus.host_txd_ack && (tcnt != hmax);
  assign rfire = (state == REQ || state == RDATA) && rwn && bus.host_rxd_vld && (rcnt != hmax);
  assign tlast = tfire && (tcnt == hmax - CW'(1));
  assign rlast = rfire && (rcnt == hmax - CW'(1));
  // Counters saturate at H, so reaching H counts as complete even without a fire this cycle.
  assign xfer_done = rwn ? (rlast || rcnt == hmax) : (tlast || tcnt == hmax);

  // Halfword k comes from buffer word k>>1 (little-endian halves).
  assign tword = buffer[tcnt[LW:1]];

  always_comb begin
    bus.host_txd = '0;
    bus.host_txm = '0;
    if ((state == REQ || state == WDATA) && !rwn) begin
      bus.host_txd = tcnt[0] ? tword[31:16] : tword[15:0];
      bus.host_txm = tcnt[0] ? wstb[3:2]    : wstb[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (wfire) buffer[widx[LW-1:0]] <= bus.c_wdat;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      rwn            <= 1'b0;
      line           <= 1'b0;
      wstb           <= '0;
      widx           <= '0;
      tcnt           <= '0;
      rcnt           <= '0;
      rlo            <= '0;
      bus.c_wrdy     <= 1'b0;
      bus.c_rvld     <= 1'b0;
      bus.c_rdat     <= '0;
      bus.c_busy     <= 1'b0;
      bus.c_done     <= 1'b0;
      bus.host_req   <= 1'b0;
      bus.host_rwn   <= 1'b0;
      bus.host_burst <= 1'b0;
      bus.host_addr  <= '0;
    end else begin
      bus.c_rvld <= 1'b0;
      bus.c_done <= 1'b0;
      if (tfire) tcnt <= tcnt + CW'(1);
      if (rfire) begin
        rcnt <= rcnt + CW'(1);
        if (!rcnt[0]) begin
          rlo <= bus.host_rxd;
        end else begin
          bus.c_rdat <= {bus.host_rxd, rlo};
          bus.c_rvld <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (bus.c_req) begin
            rwn            <= bus.c_rwn;
            line           <= bus.c_line;
            wstb           <= bus.c_line ? 4'hF : bus.c_wstb;
            widx           <= '0;
            tcnt           <= '0;
            rcnt           <= '0;
            bus.c_busy     <= 1'b1;
            bus.host_rwn   <= bus.c_rwn;
            bus.host_burst <= bus.c_line;
            bus.host_addr  <= bus.c_line ? (bus.c_addr & LINE_MASK) : {bus.c_addr[31:2], 2'b00};
            if (bus.c_rwn) begin
              state        <= REQ;
              bus.host_req <= 1'b1;
            end else begin
              state      <= WFILL;
              bus.c_wrdy <= 1'b1;
            end
          end
        end
        WFILL: begin
          if (wfire) begin
            widx <= widx + (LW + 1)'(1);
            if (widx == nmax - (LW + 1)'(1)) begin
              bus.c_wrdy   <= 1'b0;
              bus.host_req <= 1'b1;
              state        <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.host_ack) begin
            bus.host_req <= 1'b0;
            if (xfer_done) begin
              state      <= DONE;
              bus.c_done <= 1'b1;
              bus.c_busy <= 1'b0;
            end else begin
              state <= rwn ? RDATA : WDATA;
            end
          end
        end
        WDATA, RDATA: begin
          if (xfer_done) begin
            state      <= DONE;
            bus.c_done <= 1'b1;
            bus.c_busy <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
